// File: rtl/coeff_token_stats_if.sv
// Handshake and result bundle for coeff_token_stats.
//   in_valid/in_ready/in_coeff  : one zig-zag coefficient per beat, index 0 first
//   out_valid/out_ready         : per-block result handshake
//   total_coeff, trailing_ones,
//   total_zeros, t1_signs, addr : block statistics, valid while out_valid is high
// slave is the statistics block; master is the producer/consumer side.
interface coeff_token_stats_if #(
  parameter int unsigned CWIDTH = 16,
  parameter int unsigned aWIDTH = 7
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [CWIDTH-1:0] in_coeff;
  logic                     out_valid;
  logic                     out_ready;
  logic [4:0]               total_coeff;
  logic [1:0]               trailing_ones;
  logic [3:0]               total_zeros;
  logic [2:0]               t1_signs;
  logic [aWIDTH-1:0]        addr;

  modport master (
    output in_valid, in_coeff, out_ready,
    input  in_ready, out_valid, total_coeff, trailing_ones, total_zeros, t1_signs, addr
  );

  modport slave (
    input  in_valid, in_coeff, out_ready,
    output in_ready, out_valid, total_coeff, trailing_ones, total_zeros, t1_signs, addr
  );
endinterface

// File: rtl/coeff_token_stats.sv
// Streaming coeff_token front-end. Accumulates the 16 coefficients of one 4x4
// block and produces TotalCoeff, TrailingOnes, TotalZeros and trailing-one signs.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : coeff_token_stats_if slave (coefficient input + result handshake)
// addr = {trailing_ones, total_coeff} indexes the coeff_token VLC tables directly.
module coeff_token_stats #(
  parameter int unsigned CWIDTH = 16,
  parameter int unsigned NCOEFF = 16,
  parameter int unsigned aWIDTH = 7
) (
  input logic                clk,
  input logic                rst,
  coeff_token_stats_if.slave bus
);

  localparam int unsigned IW = $clog2(NCOEFF);      // coefficient index width
  localparam int unsigned NW = $clog2(NCOEFF + 1);  // nonzero count width

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NW-1:0]   nz_cnt_q, nz_cnt_d;
  logic [IW-1:0]   last_nz_q, last_nz_d;
  logic [1:0]      t1_run_q, t1_run_d;
  logic [2:0]      sign_sh_q, sign_sh_d;

  logic [NW-1:0]   tc_q, tc_d;
  logic [1:0]      t1_q, t1_d;
  logic [IW-1:0]   tz_q, tz_d;
  logic [2:0]      sg_q, sg_d;

  // Accumulator values including the current beat
  logic            accept, last_beat, is_zero, is_one;
  logic [NW-1:0]   nz_upd, tz_wide;
  logic [IW-1:0]   last_upd;
  logic [1:0]      t1_upd;
  logic [2:0]      sh_upd, sg_mask;

  always_comb begin
    accept    = bus.in_valid && (state_q == StAcc);
    last_beat = (idx_q == IW'(NCOEFF - 1));
    is_zero   = (bus.in_coeff == '0);
    // Most-negative value is neither +1 nor -1, so plain equality is enough
    is_one    = (bus.in_coeff == CWIDTH'(1)) || (bus.in_coeff == '1);

    nz_upd   = nz_cnt_q;
    last_upd = last_nz_q;
    t1_upd   = t1_run_q;
    sh_upd   = sign_sh_q;
    if (!is_zero) begin
      nz_upd   = nz_cnt_q + NW'(1);
      last_upd = idx_q;
      if (is_one) begin
        t1_upd = (t1_run_q == 2'd3) ? 2'd3 : t1_run_q + 2'd1;
        sh_upd = {sign_sh_q[1:0], bus.in_coeff[CWIDTH-1]};
      end else begin
        t1_upd = 2'd0;
        sh_upd = 3'd0;
      end
    end

    // Zeros preceding the last nonzero = positions up to it minus nonzeros
    tz_wide = NW'(last_upd) + NW'(1) - nz_upd;

    unique case (t1_upd)
      2'd0:    sg_mask = 3'b000;
      2'd1:    sg_mask = 3'b001;
      2'd2:    sg_mask = 3'b011;
      default: sg_mask = 3'b111;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nz_cnt_d  = nz_cnt_q;
    last_nz_d = last_nz_q;
    t1_run_d  = t1_run_q;
    sign_sh_d = sign_sh_q;
    tc_d      = tc_q;
    t1_d      = t1_q;
    tz_d      = tz_q;
    sg_d      = sg_q;

    unique case (state_q)
      StAcc: begin
        if (accept) begin
          nz_cnt_d  = nz_upd;
          last_nz_d = last_upd;
          t1_run_d  = t1_upd;
          sign_sh_d = sh_upd;
          if (last_beat) begin
            state_d = StHold;
            tc_d    = nz_upd;
            t1_d    = t1_upd;
            tz_d    = (nz_upd == '0) ? '0 : tz_wide[IW-1:0];
            sg_d    = sh_upd & sg_mask;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        if (bus.out_ready) begin
          state_d   = StAcc;
          idx_d     = '0;
          nz_cnt_d  = '0;
          last_nz_d = '0;
          t1_run_d  = '0;
          sign_sh_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAcc;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      nz_cnt_q  <= '0;
      last_nz_q <= '0;
      t1_run_q  <= '0;
      sign_sh_q <= '0;
      tc_q      <= '0;
      t1_q      <= '0;
      tz_q      <= '0;
      sg_q      <= '0;
    end else begin
      idx_q     <= idx_d;
      nz_cnt_q  <= nz_cnt_d;
      last_nz_q <= last_nz_d;
      t1_run_q  <= t1_run_d;
      sign_sh_q <= sign_sh_d;
      tc_q      <= tc_d;
      t1_q      <= t1_d;
      tz_q      <= tz_d;
      sg_q      <= sg_d;
    end
  end

  assign bus.in_ready      = (state_q == StAcc);
  assign bus.out_valid     = (state_q == StHold);
  assign bus.total_coeff   = 5'(tc_q);
  assign bus.trailing_ones = t1_q;
  assign bus.total_zeros   = 4'(tz_q);
  assign bus.t1_signs      = sg_q;
  assign bus.addr          = aWIDTH'({t1_q, 5'(tc_q)});

endmodule

// File: tb/tb_coeff_token_stats.sv
module tb_coeff_token_stats;

  typedef struct packed {
    logic [15:0][15:0] c;
    logic [4:0]        tc;
    logic [1:0]        t1;
    logic [3:0]        tz;
    logic [2:0]        sg;
    logic [6:0]        addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  coeff_token_stats_if #(.CWIDTH(16), .aWIDTH(7)) bus ();

  coeff_token_stats #(.CWIDTH(16), .NCOEFF(16), .aWIDTH(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: standard definitions over the whole block, scanning backwards for T1s
  function automatic vec_t model(input logic [15:0][15:0] c);
    vec_t r;
    int   last;
    bit   done;
    r      = '0;
    r.c    = c;
    last   = -1;
    for (int i = 0; i < 16; i++) begin
      if (c[i] != 16'd0) begin
        r.tc = r.tc + 5'd1;
        last = i;
      end
    end
    for (int i = 0; i < last; i++) if (c[i] == 16'd0) r.tz = r.tz + 4'd1;
    done = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (!done && c[i] != 16'd0) begin
        if ((c[i] == 16'h0001 || c[i] == 16'hFFFF) && r.t1 != 2'd3) begin
          r.sg[r.t1] = c[i][15];
          r.t1       = r.t1 + 2'd1;
        end else begin
          done = 1'b1;
        end
      end
    end
    r.addr = {r.t1, r.tc};
    return r;
  endfunction

  task automatic chk_res(input string name, input vec_t v);
    chk({name, " total_coeff"},   int'(bus.total_coeff),   int'(v.tc));
    chk({name, " trailing_ones"}, int'(bus.trailing_ones), int'(v.t1));
    chk({name, " total_zeros"},   int'(bus.total_zeros),   int'(v.tz));
    chk({name, " t1_signs"},      int'(bus.t1_signs),      int'(v.sg));
    chk({name, " addr"},          int'(bus.addr),          int'(v.addr));
  endtask

  // Inputs change #1 after posedge; outputs are sampled at the same point
  task automatic run_block(input vec_t v, input int gap_max, input int hold, input string name);
    int gaps;
    for (int i = 0; i < 16; i++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int g = 0; g < gaps; g++) begin
        bus.in_valid = 1'b0;
        bus.in_coeff = 16'($urandom);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_coeff = v.c[i];
      chk({name, " in_ready during block"}, int'(bus.in_ready), 1);
      chk({name, " early out_valid"}, int'(bus.out_valid), 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk({name, " out_valid after last beat"}, int'(bus.out_valid), 1);
    chk_res(name, v);
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_coeff  = 16'($urandom);
      @(posedge clk); #1;
      chk({name, " hold out_valid"}, int'(bus.out_valid), 1);
      chk({name, " hold in_ready"},  int'(bus.in_ready), 0);
      chk_res({name, " hold"}, v);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, " out_valid after handshake"}, int'(bus.out_valid), 0);
    chk({name, " in_ready after handshake"},  int'(bus.in_ready), 1);
  endtask

  function automatic logic [15:0] rand_coeff();
    int unsigned r;
    logic [15:0] v;
    r = $urandom_range(7, 0);
    if (r < 4)       v = 16'd0;
    else if (r == 4) v = 16'd1;
    else if (r == 5) v = 16'hFFFF;
    else if (r == 6) v = ($urandom_range(1, 0) == 1) ? 16'($urandom_range(20, 2))
                                                     : -16'($urandom_range(20, 2));
    else             v = ($urandom_range(3, 0) == 0) ? 16'h8000 : 16'($urandom);
    return v;
  endfunction

  vec_t vecs[6];
  vec_t rv;
  vec_t v2;

  initial begin
    // Directed table
    vecs[0].c = '0;
    vecs[0].c[1] = 16'd3;  vecs[0].c[3] = 16'd1;     vecs[0].c[4] = 16'hFFFF;
    vecs[0].c[5] = 16'hFFFF; vecs[0].c[7] = 16'd1;
    vecs[0].tc = 5'd5;  vecs[0].t1 = 2'd3; vecs[0].tz = 4'd3; vecs[0].sg = 3'b110;
    vecs[0].addr = 7'h65;

    vecs[1].c = '0;
    vecs[1].tc = 5'd0;  vecs[1].t1 = 2'd0; vecs[1].tz = 4'd0; vecs[1].sg = 3'b000;
    vecs[1].addr = 7'h00;

    for (int i = 0; i < 16; i++) vecs[2].c[i] = 16'd5;
    vecs[2].tc = 5'd16; vecs[2].t1 = 2'd0; vecs[2].tz = 4'd0; vecs[2].sg = 3'b000;
    vecs[2].addr = 7'h10;

    for (int i = 0; i < 16; i++) vecs[3].c[i] = 16'hFFFF;
    vecs[3].tc = 5'd16; vecs[3].t1 = 2'd3; vecs[3].tz = 4'd0; vecs[3].sg = 3'b111;
    vecs[3].addr = 7'h70;

    vecs[4].c = '0;
    vecs[4].c[0] = 16'd1; vecs[4].c[1] = 16'hFFFF; vecs[4].c[2] = 16'd4;
    vecs[4].tc = 5'd3;  vecs[4].t1 = 2'd0; vecs[4].tz = 4'd0; vecs[4].sg = 3'b000;
    vecs[4].addr = 7'h03;

    vecs[5].c = '0;
    vecs[5].c[2] = 16'hFFFF;
    vecs[5].tc = 5'd1;  vecs[5].t1 = 2'd1; vecs[5].tz = 4'd2; vecs[5].sg = 3'b001;
    vecs[5].addr = 7'h21;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_coeff  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset in_ready",      int'(bus.in_ready), 1);
    chk("reset out_valid",     int'(bus.out_valid), 0);
    chk("reset total_coeff",   int'(bus.total_coeff), 0);
    chk("reset trailing_ones", int'(bus.trailing_ones), 0);
    chk("reset total_zeros",   int'(bus.total_zeros), 0);
    chk("reset t1_signs",      int'(bus.t1_signs), 0);
    chk("reset addr",          int'(bus.addr), 0);

    for (int k = 0; k < 6; k++) run_block(vecs[k], 0, 0, $sformatf("vec%0d", k));

    // Gapped input and 5-cycle backpressure, then a back-to-back second block
    run_block(vecs[0], 3, 5, "stall blk1");
    run_block(vecs[3], 2, 0, "stall blk2");

    // Abort mid-block with reset, then a full block of 2s
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_coeff = 16'hFFFF;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort out_valid",   int'(bus.out_valid), 0);
    chk("abort in_ready",    int'(bus.in_ready), 1);
    chk("abort total_coeff", int'(bus.total_coeff), 0);
    for (int i = 0; i < 16; i++) v2.c[i] = 16'd2;
    v2.tc = 5'd16; v2.t1 = 2'd0; v2.tz = 4'd0; v2.sg = 3'b000; v2.addr = 7'h10;
    run_block(v2, 0, 0, "after abort");

    // Randomised blocks against the reference model
    for (int b = 0; b < 40; b++) begin
      logic [15:0][15:0] c;
      for (int i = 0; i < 16; i++) c[i] = rand_coeff();
      rv = model(c);
      run_block(rv, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                $sformatf("rand%0d", b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
